uart_tx_fifo: RTL and testbench

//  Byte-oriented UART transmitter: 8 data bits, LSB first, even parity, 1 stop bit, 9600 baud from CLK50MHz.

---
 rtl/uart_tx_fifo_pkg.sv | 9 +
 rtl/uart_tx_fifo_if.sv | 11 +
 rtl/uart_byte_fifo.sv | 39 +++
 rtl/uart_tx_fifo.sv | 82 ++++++++
 tb/tb_uart_tx_fifo.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_tx_fifo_pkg.sv
// uart_tx_fifo_pkg: framing constants, FSM state type and parity helper shared by the UART transmitter
package uart_tx_fifo_pkg;
  localparam int CLKS_PER_BIT_9600 = 5208;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: valid/ready byte handshake from FPGA logic into the transmitter
//  tx_data  byte to send, bit 0 goes on the line first
//  tx_valid tx_data is valid this cycle
//  tx_ready transmitter can take a byte this cycle
interface uart_tx_fifo_if;
  logic [7:0] tx_data;
  logic tx_valid;
  logic tx_ready;
  modport master(output tx_data, tx_valid, input tx_ready);
  modport slave(input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_byte_fifo.sv
// uart_byte_fifo: synchronous byte FIFO with occupancy count
//  CLK50MHz, RESET (async, active low); push/din write, pop/dout read head (show-ahead)
//  count occupancy, full/empty flags; push while full and pop while empty are ignored
module uart_byte_fifo #(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic          CLK50MHz,
  input  logic          RESET,
  input  logic          push,
  input  logic          pop,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);
  logic [7:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = count == CW'(DEPTH);
  assign empty = count == '0;
  assign do_push = push & ~full;
  assign do_pop = pop & ~empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge CLK50MHz or negedge RESET)
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  always_ff @(posedge CLK50MHz)
    if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: FIFO-buffered UART transmitter, 8 data bits LSB first, optional even parity, 1 stop bit
//  CLK50MHz    system clock
//  RESET       asynchronous, active-low reset
//  up          byte handshake (slave side)
//  tx          serial line, idle high, registered
//  busy        frame on the line or bytes queued
//  fifo_count  bytes queued, excluding the one being shifted
module uart_tx_fifo import uart_tx_fifo_pkg::*; #(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_9600,
  parameter int FIFO_DEPTH = 4,
  parameter bit PARITY_EN = 1'b1,
  localparam int CW = $clog2(FIFO_DEPTH) + 1,
  localparam int BW = $clog2(CLKS_PER_BIT)
) (
  input  logic          CLK50MHz,
  input  logic          RESET,
  uart_tx_fifo_if.slave up,
  output logic          tx,
  output logic          busy,
  output logic [CW-1:0] fifo_count
);
  state_t state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0] bit_idx, bit_idx_n;
  logic [7:0] shift, shift_n, head;
  logic par, par_n, pop, full, empty, baud_end, tx_n;
  uart_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK50MHz, .RESET, .push(up.tx_valid), .pop, .din(up.tx_data),
    .dout(head), .count(fifo_count), .full, .empty
  );
  assign up.tx_ready = ~full;
  assign busy = (state != IDLE) | ~empty;
  assign baud_end = baud == BW'(CLKS_PER_BIT - 1);
  always_comb begin
    state_n = state;
    baud_n = baud_end ? '0 : baud + 1'b1;
    bit_idx_n = bit_idx;
    shift_n = shift;
    par_n = par;
    pop = 1'b0;
    if (state == DATA && baud_end) begin
      shift_n = shift >> 1;
      bit_idx_n = bit_idx + 1'b1;
    end
    case (state)
      IDLE:    pop = ~empty;
      START:   if (baud_end) state_n = DATA;
      DATA:    if (baud_end && bit_idx == 3'(DATA_BITS - 1)) state_n = PARITY_EN ? PARITY : STOP;
      PARITY:  if (baud_end) state_n = STOP;
      STOP: begin
        pop = baud_end & ~empty;
        if (baud_end) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // a pop always starts a new frame, either from idle or straight out of the stop bit
    if (pop) begin
      state_n = START;
      baud_n = '0;
      shift_n = head;
      par_n = even_parity(head);
      bit_idx_n = '0;
    end
    tx_n = state == START ? 1'b0 : state == DATA ? shift[0] : state == PARITY ? par : 1'b1;
  end
  always_ff @(posedge CLK50MHz or negedge RESET)
    if (!RESET) begin
      state <= IDLE;
      baud <= '0;
      bit_idx <= '0;
      shift <= '0;
      par <= 1'b0;
      tx <= 1'b1;
    end else begin
      state <= state_n;
      baud <= baud_n;
      bit_idx <= bit_idx_n;
      shift <= shift_n;
      par <= par_n;
      tx <= tx_n;
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: checks the transmitter against a frame-level line model plus hand-computed frames
module tb_uart_tx_fifo;
  localparam int C = 16, D = 4, CW = 3;
  logic CLK50MHz = 1'b0, RESET = 1'b0;
  logic v [2];
  logic [7:0] dat [2];
  logic tx [2], busy [2];
  logic [CW-1:0] cnt [2];
  int n_chk = 0, n_fail = 0, cyc = 0;
  bit mv = 1'b0;
  logic [7:0] mq [2][$];
  bit ml [2][$];
  bit e_tx [2], e_busy [2], e_rdy [2];
  int e_cnt [2];
  uart_tx_fifo_if ifa(), ifb();
  assign ifa.tx_valid = v[0];
  assign ifa.tx_data = dat[0];
  assign ifb.tx_valid = v[1];
  assign ifb.tx_data = dat[1];
  uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .PARITY_EN(1'b1)) dut_p (
    .CLK50MHz, .RESET, .up(ifa), .tx(tx[0]), .busy(busy[0]), .fifo_count(cnt[0]));
  uart_tx_fifo #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .PARITY_EN(1'b0)) dut_n (
    .CLK50MHz, .RESET, .up(ifb), .tx(tx[1]), .busy(busy[1]), .fifo_count(cnt[1]));
  always #5 CLK50MHz = ~CLK50MHz;
  always @(posedge CLK50MHz) cyc <= cyc + 1;
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  function automatic void build(int d, logic [7:0] b);
    bit bits [$];
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(b[i]);
    if (d == 0) bits.push_back(^b);
    bits.push_back(1'b1);
    foreach (bits[i]) repeat (C) ml[d].push_back(bits[i]);
  endfunction
  // line model: each queued byte becomes a list of per-clock line values; a new frame is
  // queued the cycle after the FIFO holds a byte and the line schedule has run dry
  always @(posedge CLK50MHz or negedge RESET) begin
    for (int d = 0; d < 2; d++) begin
      bit rdy;
      rdy = mq[d].size() != D;
      if (!RESET) begin
        mq[d].delete();
        ml[d].delete();
        e_tx[d] = 1'b1;
      end else begin
        e_tx[d] = ml[d].size() != 0 ? ml[d].pop_front() : 1'b1;
        if (ml[d].size() == 0 && mq[d].size() != 0) build(d, mq[d].pop_front());
        if (v[d] && rdy) mq[d].push_back(dat[d]);
      end
      e_busy[d] = ml[d].size() != 0 || mq[d].size() != 0;
      e_cnt[d] = mq[d].size();
      e_rdy[d] = mq[d].size() != D;
    end
    mv = 1'b1;
  end
  always @(negedge CLK50MHz)
    if (mv)
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("model.d%0d.tx", d), 32'(tx[d]), 32'(e_tx[d]));
        chk($sformatf("model.d%0d.busy", d), 32'(busy[d]), 32'(e_busy[d]));
        chk($sformatf("model.d%0d.count", d), 32'(cnt[d]), 32'(e_cnt[d]));
        chk($sformatf("model.d%0d.ready", d), 32'(d == 0 ? ifa.tx_ready : ifb.tx_ready), 32'(e_rdy[d]));
      end
  task automatic sync();
    @(posedge CLK50MHz);
    #2;
  endtask
  // holds valid, scrambling data while the FIFO is full, and returns 2ns after the accept edge
  task automatic push(int d, logic [7:0] b);
    int k = 0;
    v[d] = 1'b1;
    while (!e_rdy[d] && k < 1000) begin
      dat[d] = 8'($urandom);
      sync();
      k++;
    end
    chk("push.ready_wait", 32'(k < 1000), 32'd1);
    dat[d] = b;
    sync();
  endtask
  task automatic rx_frame(int d, output logic [7:0] b, output logic p, output logic s, output int t0);
    int k = 0;
    b = '0;
    p = 1'b0;
    s = 1'b0;
    do begin
      @(negedge CLK50MHz);
      k++;
    end while (tx[d] !== 1'b0 && k < 1000);
    chk("rx.start_seen", 32'(k < 1000), 32'd1);
    t0 = cyc;
    repeat (C / 2 - 1) @(negedge CLK50MHz);
    chk("rx.start_mid", 32'(tx[d]), 32'd0);
    for (int i = 0; i < 8; i++) begin
      repeat (C) @(negedge CLK50MHz);
      b[i] = tx[d];
    end
    if (d == 0) begin
      repeat (C) @(negedge CLK50MHz);
      p = tx[d];
    end
    repeat (C) @(negedge CLK50MHz);
    s = tx[d];
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1);
  end
  initial begin
    logic [7:0] b;
    logic p, s;
    int t0, tp;
    logic [7:0] lb [4];
    logic lp [4];
    v[0] = 1'b0;
    v[1] = 1'b0;
    dat[0] = '0;
    dat[1] = '0;
    repeat (3) @(posedge CLK50MHz);
    #2;
    chk("reset.tx", 32'(tx[0]), 32'd1);
    chk("reset.busy", 32'(busy[0]), 32'd0);
    chk("reset.count", 32'(cnt[0]), 32'd0);
    chk("reset.ready", 32'(ifa.tx_ready), 32'd1);
    RESET = 1'b1;
    repeat (3) sync();
    push(0, 8'hA5);
    v[0] = 1'b0;
    rx_frame(0, b, p, s, t0);
    chk("t1.byte", 32'(b), 32'hA5);
    chk("t1.parity", 32'(p), 32'd0);
    chk("t1.stop", 32'(s), 32'd1);
    repeat (20) @(negedge CLK50MHz);
    chk("t1.busy_drop", 32'(busy[0]), 32'd0);
    sync();
    push(0, 8'h07);
    v[0] = 1'b0;
    @(negedge CLK50MHz);
    chk("t2.tx_edge_n", 32'(tx[0]), 32'd1);
    @(negedge CLK50MHz);
    chk("t2.tx_edge_n1", 32'(tx[0]), 32'd1);
    @(negedge CLK50MHz);
    chk("t2.tx_edge_n2", 32'(tx[0]), 32'd0);
    repeat (12 * C) @(posedge CLK50MHz);
    sync();
    fork
      begin
        for (int i = 1; i <= 5; i++) push(0, 8'(i));
        chk("t3.count_full", 32'(cnt[0]), 32'd4);
        chk("t3.ready_full", 32'(ifa.tx_ready), 32'd0);
        push(0, 8'h06);
        v[0] = 1'b0;
      end
      begin
        tp = 0;
        for (int i = 1; i <= 6; i++) begin
          rx_frame(0, b, p, s, t0);
          chk($sformatf("t3.byte%0d", i), 32'(b), 32'(i));
          chk($sformatf("t3.stop%0d", i), 32'(s), 32'd1);
          if (i > 1) chk($sformatf("t3.spacing%0d", i), 32'(t0 - tp), 32'(11 * C));
          tp = t0;
        end
      end
    join
    repeat (20) @(posedge CLK50MHz);
    sync();
    push(0, 8'h3C);
    push(0, 8'h11);
    push(0, 8'h22);
    v[0] = 1'b0;
    repeat (30) @(posedge CLK50MHz);
    #3 RESET = 1'b0;
    #1;
    chk("t4.tx", 32'(tx[0]), 32'd1);
    chk("t4.count", 32'(cnt[0]), 32'd0);
    chk("t4.ready", 32'(ifa.tx_ready), 32'd1);
    chk("t4.busy", 32'(busy[0]), 32'd0);
    #10 RESET = 1'b1;
    repeat (300) @(posedge CLK50MHz);
    #2;
    chk("t4.idle_tx", 32'(tx[0]), 32'd1);
    chk("t4.idle_busy", 32'(busy[0]), 32'd0);
    lb = '{8'h00, 8'hFF, 8'h55, 8'h80};
    lp = '{1'b0, 1'b0, 1'b0, 1'b1};
    sync();
    fork
      begin
        for (int i = 0; i < 4; i++) push(0, lb[i]);
        v[0] = 1'b0;
      end
      for (int i = 0; i < 4; i++) begin
        rx_frame(0, b, p, s, t0);
        chk($sformatf("t5.byte%0d", i), 32'(b), 32'(lb[i]));
        chk($sformatf("t5.parity%0d", i), 32'(p), 32'(lp[i]));
        chk($sformatf("t5.stop%0d", i), 32'(s), 32'd1);
      end
    join
    repeat (20) @(posedge CLK50MHz);
    sync();
    push(1, 8'hC3);
    v[1] = 1'b0;
    rx_frame(1, b, p, s, t0);
    chk("t6.byte", 32'(b), 32'hC3);
    chk("t6.stop", 32'(s), 32'd1);
    repeat (10) @(negedge CLK50MHz);
    chk("t6.frame_done", 32'(busy[1]), 32'd0);
    repeat (10) @(posedge CLK50MHz);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
